// File: rtl/sec02_stream_serializer.sv
// Serializer: splits one p_nwords-word message into p_nwords narrow words, word 0 first.
// Latency: word 0 valid the cycle after the message is accepted; 1 word/cycle sustained.
// Backpressure: holds the current word while ostream_rdy is low; accepts a new message only when idle or on the last word's transfer.
module sec02_stream_serializer #(
  parameter int p_word_nbits = 32,
  parameter int p_nwords     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             istream_val,
  output logic                             istream_rdy,
  input  logic [p_nwords*p_word_nbits-1:0] istream_msg,
  output logic                             ostream_val,
  input  logic                             ostream_rdy,
  output logic [p_word_nbits-1:0]          ostream_msg
);

  localparam int c_msg_nbits = p_nwords * p_word_nbits;
  localparam int c_idx_nbits = (p_nwords > 1) ? $clog2(p_nwords) : 1;
  localparam logic [c_idx_nbits-1:0] c_last_idx = c_idx_nbits'(p_nwords - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   r_state;
  logic [c_idx_nbits-1:0]   r_idx;
  logic [c_msg_nbits-1:0]   r_msg;

  logic w_isend;
  logic w_osend;
  logic w_last;

  // Output valid comes straight from the state register, so nothing on the
  // input side can reach the output side combinationally.
  assign ostream_val = (r_state == SEND);
  assign w_last      = (r_idx == c_last_idx);
  assign w_osend     = ostream_val & ostream_rdy;

  // Ready depends on ostream_rdy only on the last word, which is what allows
  // back-to-back messages without a bubble cycle.
  assign istream_rdy = !reset & ((r_state == IDLE) | (w_osend & w_last));
  assign w_isend     = istream_val & istream_rdy;

  // Select the word addressed by the index out of the held message.
  always_comb begin
    ostream_msg = '0;
    for (int i = 0; i < p_nwords; i++) begin
      if (r_idx == c_idx_nbits'(i)) begin
        ostream_msg = r_msg[i*p_word_nbits +: p_word_nbits];
      end
    end
  end

  // Control FSM: capture a message, walk the index, reload or drop back to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_msg   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_isend) begin
            r_msg   <= istream_msg;
            r_idx   <= '0;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (w_osend) begin
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
            end else if (w_isend) begin
              r_msg   <= istream_msg;
              r_idx   <= '0;
              r_state <= SEND;
            end else begin
              r_idx   <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sec02_stream_serializer.sv
// Directed bench for the stream serializer: default 2x32 instance plus a 4x8 instance.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Random source/sink delays exercise backpressure in both directions.
module tb_sec02_stream_serializer;

  logic        clk;
  logic        reset;

  logic        ival;
  logic        irdy;
  logic [63:0] imsg;
  logic        oval;
  logic        ordy;
  logic [31:0] omsg;

  logic        ival4;
  logic        irdy4;
  logic [31:0] imsg4;
  logic        oval4;
  logic        ordy4;
  logic [7:0]  omsg4;

  int n_checks;
  int n_errors;

  sec02_stream_serializer #(.p_word_nbits(32), .p_nwords(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .istream_val (ival),
    .istream_rdy (irdy),
    .istream_msg (imsg),
    .ostream_val (oval),
    .ostream_rdy (ordy),
    .ostream_msg (omsg)
  );

  sec02_stream_serializer #(.p_word_nbits(8), .p_nwords(4)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .istream_val (ival4),
    .istream_rdy (irdy4),
    .istream_msg (imsg4),
    .ostream_val (oval4),
    .ostream_rdy (ordy4),
    .ostream_msg (omsg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [63:0] m2   [3];
  logic        ev2  [8];
  logic [31:0] ew2  [8];
  logic        er2  [8];
  logic        ev4  [10];
  logic [7:0]  ew4  [10];
  logic        er4  [10];
  logic [63:0] rmsg [50];
  logic [31:0] exp_w [100];
  int          k;
  int          got;
  int          sdly;
  int          budget;
  int          d;
  int          sb;
  logic        sent;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    ival  = 1'b0; imsg  = '0; ordy  = 1'b0;
    ival4 = 1'b0; imsg4 = '0; ordy4 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_oval", oval, 0);
    check("rst_omsg", omsg, 0);
    check("rst_irdy", irdy, 0);
    check("rst_oval4", oval4, 0);
    @(negedge clk); reset = 1'b0; #1;
    check("post_rst_irdy", irdy, 1);
    check("post_rst_irdy4", irdy4, 1);

    // Test 1: single message, sink always ready
    @(negedge clk); ival = 1'b1; imsg = 64'h0000_0002_0000_0001; ordy = 1'b1; #1;
    check("t1_accept_rdy", irdy, 1);
    check("t1_accept_oval", oval, 0);
    @(negedge clk); ival = 1'b0; #1;
    check("t1_w0_val", oval, 1);
    check("t1_w0_msg", omsg, 32'h1);
    check("t1_w0_irdy", irdy, 0);
    @(negedge clk); #1;
    check("t1_w1_val", oval, 1);
    check("t1_w1_msg", omsg, 32'h2);
    check("t1_w1_irdy", irdy, 1);
    @(negedge clk); #1;
    check("t1_idle_val", oval, 0);

    // Test 2: three messages back to back
    m2[0] = 64'h0000_0002_0000_0001;
    m2[1] = 64'h0000_0004_0000_0003;
    m2[2] = 64'h0000_0006_0000_0005;
    ev2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ew2 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0};
    er2 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    k = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ival = (k < 3);
      imsg = (k < 3) ? m2[k] : 64'h0;
      ordy = 1'b1;
      #1;
      check($sformatf("t2_val_c%0d", c), oval, ev2[c]);
      check($sformatf("t2_rdy_c%0d", c), irdy, er2[c]);
      if (ev2[c]) check($sformatf("t2_msg_c%0d", c), omsg, ew2[c]);
      if (ival && irdy) k++;
    end
    ival = 1'b0;

    // Test 3: sink stalls on word 0, then on word 1
    @(negedge clk); ival = 1'b1; imsg = 64'hdead_beef_cafe_f00d; ordy = 1'b0; #1;
    check("t3_accept_rdy", irdy, 1);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk); ival = 1'b0; ordy = 1'b0; #1;
      check($sformatf("t3_stall%0d_val", s), oval, 1);
      check($sformatf("t3_stall%0d_msg", s), omsg, 32'hcafe_f00d);
      check($sformatf("t3_stall%0d_irdy", s), irdy, 0);
    end
    @(negedge clk); ordy = 1'b1; #1;
    check("t3_w0_msg", omsg, 32'hcafe_f00d);
    check("t3_w0_irdy", irdy, 0);
    @(negedge clk); ordy = 1'b0; #1;
    check("t3_w1_stall_msg", omsg, 32'hdead_beef);
    check("t3_w1_stall_irdy", irdy, 0);
    @(negedge clk); ordy = 1'b1; #1;
    check("t3_w1_msg", omsg, 32'hdead_beef);
    check("t3_w1_irdy", irdy, 1);
    @(negedge clk); #1;
    check("t3_idle_val", oval, 0);

    // Test 4: random source and sink delays
    for (int i = 0; i < 50; i++) begin
      rmsg[i] = {$urandom, $urandom};
      exp_w[2*i]   = rmsg[i][31:0];
      exp_w[2*i+1] = rmsg[i][63:32];
    end
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          d = $urandom_range(0, 5);
          repeat (d) begin
            @(negedge clk); ival = 1'b0;
          end
          sent = 1'b0;
          sb = 0;
          while (!sent && sb < 1000) begin
            @(negedge clk); ival = 1'b1; imsg = rmsg[i]; #1;
            if (irdy) sent = 1'b1;
            sb++;
          end
          check("t4_accept", sent, 1);
        end
        @(negedge clk); ival = 1'b0;
      end
      begin
        got = 0;
        budget = 0;
        sdly = $urandom_range(0, 5);
        while (got < 100 && budget < 5000) begin
          @(negedge clk); ordy = (sdly == 0); #1;
          if (oval && ordy) begin
            check($sformatf("t4_word%0d", got), omsg, exp_w[got]);
            got++;
            sdly = $urandom_range(0, 5);
          end else if (sdly > 0) begin
            sdly--;
          end
          budget++;
        end
        check("t4_word_count", got, 100);
      end
    join
    @(negedge clk); ival = 1'b0; ordy = 1'b1; #1;
    check("t4_drained_val", oval, 0);

    // Test 5: reset while the second word is pending
    @(negedge clk); ival = 1'b1; imsg = 64'h0000_00bb_0000_00aa; ordy = 1'b1; #1;
    check("t5_accept_rdy", irdy, 1);
    @(negedge clk); ival = 1'b0; #1;
    check("t5_w0_val", oval, 1);
    check("t5_w0_msg", omsg, 32'haa);
    @(negedge clk); reset = 1'b1; ordy = 1'b0; #1;
    check("t5_rst_irdy", irdy, 0);
    @(negedge clk); #1;
    check("t5_rst_val", oval, 0);
    check("t5_rst_msg", omsg, 0);
    @(negedge clk); reset = 1'b0; ordy = 1'b1; #1;
    check("t5_post_val", oval, 0);
    check("t5_post_irdy", irdy, 1);
    ival = 1'b1; imsg = 64'h0000_0002_0000_0001;
    @(negedge clk); ival = 1'b0; #1;
    check("t5_n0_val", oval, 1);
    check("t5_n0_msg", omsg, 32'h1);
    @(negedge clk); #1;
    check("t5_n1_val", oval, 1);
    check("t5_n1_msg", omsg, 32'h2);
    @(negedge clk); #1;
    check("t5_end_val", oval, 0);

    // Test 6: four 8-bit words, back-to-back to cross the index wrap
    ev4 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ew4 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    er4 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      ival4 = (c == 0) || (c == 4);
      imsg4 = (c == 0) ? 32'h4433_2211 : 32'h8877_6655;
      ordy4 = 1'b1;
      #1;
      check($sformatf("t6_val_c%0d", c), oval4, ev4[c]);
      check($sformatf("t6_rdy_c%0d", c), irdy4, er4[c]);
      if (ev4[c]) check($sformatf("t6_msg_c%0d", c), omsg4, ew4[c]);
    end
    ival4 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
